// File: rtl/product_acc_pkg.sv
// Shared types and helpers for the product accumulator: FSM state encoding,
// the stream byte width, and the byte-count calculation.
package product_acc_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } acc_state_t;

   localparam int BYTE_W = 8;

   function automatic int byte_count(input int acc_w);
      return acc_w / BYTE_W;
   endfunction

endpackage

// File: rtl/product_acc_add.sv
// Combinational accumulate step returning {sum, carry}.
// With PRODUCT_ACC_SATURATE_EN defined, a carry-out clamps the sum to all-ones.
module acc_add #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   logic [ACC_W:0] full;

   assign full  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
   assign carry = full[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
   // Once clamped, any further non-zero product carries again, so it stays clamped.
   assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
   assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of COUNT_N products and drains each sum LSB-byte-first over a
// byte-wide valid/ready stream. Optional macro: PRODUCT_ACC_SATURATE_EN.
//
// state | meaning
// ACCUM | accepting products into acc; flush or the last product starts a drain
// DRAIN | presenting acc one byte per handshake; products refused
module product_accumulator
   import product_acc_pkg::*;
#(
   parameter int PROD_W  = 8,
   parameter int ACC_W   = 16,
   parameter int COUNT_N = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_last,
   output logic              ovf
);

   localparam int N_BYTES = byte_count(ACC_W);
   localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int CNT_W   = (COUNT_N > 1) ? $clog2(COUNT_N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_N - 1);

   acc_state_t       state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] byte_idx;
   logic [ACC_W-1:0] sum;
   logic             carry;
   logic [ACC_W-1:0] acc_shifted;

   acc_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_add (
      .acc   (acc),
      .prod  (prod_data),
      .sum   (sum),
      .carry (carry)
   );

   assign prod_ready  = (state == ACCUM);
   assign out_valid   = (state == DRAIN);
   assign acc_shifted = acc >> (BYTE_W * byte_idx);
   assign out_data    = out_valid ? acc_shifted[BYTE_W-1:0] : 8'h00;
   assign out_last    = out_valid && (byte_idx == IDX_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ACCUM;
         acc      <= '0;
         cnt      <= '0;
         byte_idx <= '0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (prod_valid) begin
                  acc <= sum;
                  cnt <= cnt + 1'b1;
                  if (carry) ovf <= 1'b1;
               end
               if ((prod_valid && cnt == CNT_LAST) || flush) state <= DRAIN;
            end
            DRAIN: begin
               if (out_ready) begin
                  if (byte_idx == IDX_LAST) begin
                     state    <= ACCUM;
                     acc      <= '0;
                     cnt      <= '0;
                     byte_idx <= '0;
                     ovf      <= 1'b0;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: a sum-level reference model,
// a per-cycle compare process, directed literal checks and a random phase.
module tb_product_accumulator;

   localparam int ACC_W   = 16;
   localparam int COUNT_N = 8;
   localparam int NB      = ACC_W / 8;
   localparam longint MAXV = (64'd1 << ACC_W) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       prod_valid = 1'b0;
   logic [7:0] prod_data = 8'h00;
   logic       flush = 1'b0;
   logic       out_ready = 1'b1;
   logic       prod_ready, out_valid, out_last, ovf;
   logic [7:0] out_data;

   logic       p8_valid = 1'b0;
   logic [7:0] p8_data = 8'h00;
   logic       o8_ready = 1'b0;
   logic       p8_ready, o8_valid, o8_last, ovf8;
   logic [7:0] o8_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   product_accumulator #(.PROD_W(8), .ACC_W(ACC_W), .COUNT_N(COUNT_N)) dut (
      .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(prod_ready),
      .prod_data(prod_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .ovf(ovf)
   );

   product_accumulator #(.PROD_W(8), .ACC_W(8), .COUNT_N(4)) dut8 (
      .clk(clk), .rst(rst), .prod_valid(p8_valid), .prod_ready(p8_ready),
      .prod_data(p8_data), .flush(1'b0), .out_valid(o8_valid),
      .out_ready(o8_ready), .out_data(o8_data), .out_last(o8_last), .ovf(ovf8)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: true (unbounded) block sum, products taken, drain position.
   longint m_total = 0;
   int     m_n     = 0;
   bit     m_drain = 0;
   int     m_byte  = 0;

   typedef struct { logic [7:0] b; logic last; logic ov; } ebyte_t;
   ebyte_t emitted[$];

   function automatic longint m_acc();
`ifdef PRODUCT_ACC_SATURATE_EN
      return (m_total > MAXV) ? MAXV : m_total;
`else
      return m_total % (MAXV + 1);
`endif
   endfunction

   function automatic logic [7:0] m_out_byte();
      return m_drain ? 8'((m_acc() >> (8 * m_byte)) & 255) : 8'h00;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_total = 0; m_n = 0; m_drain = 0; m_byte = 0;
      end else if (!m_drain) begin
         if (prod_valid) begin
            m_total += prod_data;
            m_n++;
         end
         if ((prod_valid && m_n == COUNT_N) || flush) m_drain = 1;
      end else if (out_ready) begin
         emitted.push_back('{m_out_byte(), m_byte == NB - 1, m_total > MAXV});
         if (m_byte == NB - 1) begin
            m_total = 0; m_n = 0; m_drain = 0; m_byte = 0;
         end else begin
            m_byte++;
         end
      end
   end

   always @(negedge clk) begin
      chk("prod_ready", 32'(prod_ready), 32'(!m_drain));
      chk("out_valid",  32'(out_valid),  32'(m_drain));
      chk("out_data",   32'(out_data),   32'(m_out_byte()));
      chk("out_last",   32'(out_last),   32'(m_drain && m_byte == NB - 1));
      chk("ovf",        32'(ovf),        32'(m_total > MAXV));
   end

   task automatic send_prod(input logic [7:0] d, input logic fl);
      int t = 0;
      @(negedge clk);
      while (!prod_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("send_timeout", 32'(t), 32'd0);
      prod_valid = 1'b1; prod_data = d; flush = fl;
      @(negedge clk);
      prod_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic wait_drained();
      int t = 0;
      while (out_valid && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("drain_timeout", 32'(t), 32'd0);
   endtask

   task automatic chk_emitted(input string name, input logic [7:0] b0, input logic [7:0] b1);
      chk({name, "_count"}, 32'(emitted.size()), 32'd2);
      if (emitted.size() == 2) begin
         chk({name, "_b0"}, 32'(emitted[0].b), 32'(b0));
         chk({name, "_b1"}, 32'(emitted[1].b), 32'(b1));
         chk({name, "_last0"}, 32'(emitted[0].last), 32'd0);
         chk({name, "_last1"}, 32'(emitted[1].last), 32'd1);
      end
   endtask

   initial begin
      logic [7:0] blk [8];
      logic [7:0] exp8;
      blk = '{8'd225, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};

      #12;
      chk("rst_prod_ready", 32'(prod_ready), 32'd1);
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_out_data",   32'(out_data),   32'd0);
      chk("rst_out_last",   32'(out_last),   32'd0);
      chk("rst_ovf",        32'(ovf),        32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Full block of 8 products: 253 = 0x00FD
      emitted.delete();
      out_ready = 1'b1;
      foreach (blk[i]) send_prod(blk[i], 1'b0);
      wait_drained();
      chk_emitted("blk253", 8'hFD, 8'h00);
      if (emitted.size() == 2) chk("blk253_ovf", 32'(emitted[1].ov), 32'd0);
      @(negedge clk);
      chk("blk253_ready_back", 32'(prod_ready), 32'd1);

      // Early flush after three products, then flush of an empty block
      emitted.delete();
      send_prod(8'd10, 1'b0); send_prod(8'd20, 1'b0); send_prod(8'd30, 1'b0);
      pulse_flush();
      wait_drained();
      chk_emitted("flush60", 8'h3C, 8'h00);
      emitted.delete();
      pulse_flush();
      wait_drained();
      chk_emitted("flush0", 8'h00, 8'h00);

      // 8th product arrives with flush: exactly one drain including it
      emitted.delete();
      for (int i = 0; i < 7; i++) send_prod(8'd1, 1'b0);
      send_prod(8'd1, 1'b1);
      wait_drained();
      repeat (5) @(negedge clk);
      chk_emitted("flush8th", 8'h08, 8'h00);
      chk("flush8th_no_redrain", 32'(out_valid), 32'd0);

      // Backpressure: byte held, products ignored while draining
      emitted.delete();
      out_ready = 1'b0;
      foreach (blk[i]) send_prod(blk[i], 1'b0);
      prod_valid = 1'b1; prod_data = 8'd99; flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_data",  32'(out_data),   32'hFD);
         chk("hold_valid", 32'(out_valid),  32'd1);
         chk("hold_ready", 32'(prod_ready), 32'd0);
      end
      prod_valid = 1'b0; flush = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      wait_drained();
      chk_emitted("hold", 8'hFD, 8'h00);

      // 8-bit accumulator, 4 x 225 = 900 overflows
`ifdef PRODUCT_ACC_SATURATE_EN
      exp8 = 8'hFF;
`else
      exp8 = 8'h84;
`endif
      @(negedge clk);
      p8_valid = 1'b1; p8_data = 8'd225;
      repeat (4) @(negedge clk);
      p8_valid = 1'b0;
      chk("acc8_valid", 32'(o8_valid), 32'd1);
      chk("acc8_data",  32'(o8_data),  32'(exp8));
      chk("acc8_last",  32'(o8_last),  32'd1);
      chk("acc8_ovf",   32'(ovf8),     32'd1);
      o8_ready = 1'b1;
      @(negedge clk);
      chk("acc8_done_ovf",   32'(ovf8),     32'd0);
      chk("acc8_done_ready", 32'(p8_ready), 32'd1);

      // Reset in the middle of a drain discards everything
      emitted.delete();
      out_ready = 1'b0;
      foreach (blk[i]) send_prod(blk[i], 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid),  32'd0);
      chk("mid_rst_data",  32'(out_data),   32'd0);
      chk("mid_rst_last",  32'(out_last),   32'd0);
      chk("mid_rst_ready", 32'(prod_ready), 32'd1);
      chk("mid_rst_ovf",   32'(ovf),        32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      emitted.delete();
      send_prod(8'd5, 1'b0);
      pulse_flush();
      wait_drained();
      chk_emitted("post_rst", 8'h05, 8'h00);

      // Random traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         prod_valid = ($urandom_range(0, 3) != 0);
         prod_data  = 8'($urandom_range(0, 255));
         flush      = ($urandom_range(0, 15) == 0);
         out_ready  = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      prod_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      wait_drained();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
